soc_system_rows_in_pio: RTL

- Avalon-MM slave input PIO. It is the inbound counterpart of the columns output PIO.
- It samples an asynchronous WIDTH-bit external bus (row sense lines from the GOL fabric). The bus passes through a synchronizer chain.
- It detects per-bit edges into a sticky edge-capture register and raises a maskable level interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA bridge beside the other PIOs.

---
 rtl/soc_system_rows_in_pio.sv | 112 +++++++++++
 1 files changed

// File: rtl/soc_system_rows_in_pio.sv
// Avalon-MM input PIO for the GOL row sense lines: synchronizes in_port, captures per-bit edges
// into a sticky write-1-to-clear register and raises a maskable level interrupt.
module soc_system_rows_in_pio #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned PrimeMax = SYNC_STAGES + 1;
  localparam int unsigned PrimeW   = $clog2(PrimeMax + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [WIDTH-1:0]                  edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [PrimeW-1:0]                 prime_q, prime_d;
  logic [31:0]                       readdata_q, readdata_d;
  logic                              irq_q, irq_d;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clear;
  logic             primed;
  logic             wr_en;
  logic             unused_writedata;

  assign sync_in          = sync_q[SYNC_STAGES-1];
  assign primed           = (prime_q == PrimeW'(PrimeMax));
  assign wr_en            = chipselect & ~write_n;
  assign unused_writedata = ^writedata;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d  = sync_in;
    prime_d = primed ? prime_q : prime_q + PrimeW'(1);
  end

  // Detection is held off until the reset-zero pipeline has flushed through prev.
  always_comb begin
    detect = '0;
    if (primed) begin
      if (EDGE_TYPE == 0) begin
        detect = sync_in & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
        detect = ~sync_in & prev_q;
      end else begin
        detect = sync_in ^ prev_q;
      end
    end
  end

  always_comb begin
    clear      = '0;
    irq_mask_d = irq_mask_q;
    if (wr_en && address == 2'd3) begin
      clear = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd2) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    // Set wins over a simultaneous clear.
    edge_capture_d = (edge_capture_q & ~clear) | detect;
    irq_d          = |(edge_capture_d & irq_mask_d);
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d[WIDTH-1:0] = sync_in;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q         <= '0;
      prev_q         <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      prime_q        <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      prime_q        <= prime_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
